cordic_arbiter: RTL
===================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter SZ, default 16, width of the CORDIC X/Y inputs; outputs are SZ+1 bits.
REQ-002 Parameter LAT, default 17, CORDIC pipeline latency in clocks from input register to output.
REQ-003 CLK_100MHz  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  in  1 each  requester n presents an operation.
REQ-006 req0_ready, req1_ready  out  1 each  requester n accepted this cycle.
REQ-007 req0_angle, req1_angle  in  32 each  phase, full circle = 2^32.
REQ-008 req0_x, req0_y, req1_x, req1_y  in  SZ each  CORDIC start vector.
REQ-009 cordic_angle  out  32;  cordic_xin, cordic_yin  out  SZ  registered drive to the CORDIC.
REQ-010 cordic_xout, cordic_yout  in  SZ+1  CORDIC results.
REQ-011 rsp0_valid, rsp1_valid  out  1 each  one-cycle pulse, result belongs to requester n.
REQ-012 rsp_x, rsp_y  out  SZ+1  registered result, shared by both requesters.
REQ-013 busy  out  1  at least one operation in flight.

Function
REQ-014 Accept occurs on a rising edge where reqn_valid and reqn_ready are both high; no back-pressure on responses.
REQ-015 readyn is combinational from the valids and the priority pointer; at most one ready is high per cycle.
REQ-016 Only one valid high -> that requester ready.
REQ-017 Both valid high -> the requester not granted last is ready (round robin); after reset requester 0 wins the first tie.
REQ-018 Priority pointer updates only on an accept, to the index just granted.
REQ-019 Neither valid high -> both ready low, cordic_* registers hold their values, and no tag is issued.
REQ-020 On accept at edge k, cordic_angle/xin/yin load the granted operands at edge k.
REQ-021 A {valid, tag} entry is issued into an LAT-deep delay line at edge k.
REQ-022 At edge k+LAT+1, rsp_x/rsp_y capture cordic_xout/yout and rsp<tag>_valid pulses high for one cycle.
REQ-023 Throughput is one accept per cycle; back-to-back accepts yield back-to-back responses in accept order.
REQ-024 rsp_x/rsp_y hold their last value while no response is pulsing.
REQ-025 busy is high when any delay-line entry is valid or any rsp valid is high.
REQ-026 Widths pass straight through with no truncation or sign change; the arbiter performs no arithmetic on the data.

Reset
REQ-027 reset clears cordic_angle/xin/yin, rsp_x/rsp_y and rsp valids to 0, and resets the pointer to favour 0.
REQ-028 reset clears every delay-line entry; in-flight operations are dropped and no response pulses for them.
REQ-029 While reset is high, both ready outputs are 0.

Configuration
REQ-030 Macro CORDIC_ARB_STATS_EN defined -> add outputs grant_cnt0 and grant_cnt1, 16 bits each.
REQ-031 Each counter increments once per accept of its requester, saturates at 0xFFFF, and is cleared by reset.
REQ-032 Macro CORDIC_ARB_STATS_EN undefined -> the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-033 Shared package cordic_pkg holds ANGLE_W=32, the default SZ, the tag typedef (1 bit, requester index) and the delay-line entry typedef {valid, tag}.
REQ-034 Sub-module cordic_tag_pipe implements the LAT-deep {valid, tag} shift register with synchronous clear; the arbiter instantiates it once.

Verification
REQ-035 Only req0 valid, angle 0x40000000, x 19429, y 0 -> req0_ready=1, and rsp0_valid pulses exactly LAT+1 cycles after accept with the CORDIC result.
REQ-036 Both valid continuously for 8 cycles after reset -> grants 0,1,0,1,0,1,0,1 and responses return in that order with matching tags.
REQ-037 360 back-to-back req1 accepts, angles i*2^32/360 -> 360 consecutive rsp1_valid pulses with no gaps; busy falls 1 cycle after the last pulse.
REQ-038 Reset asserted 5 cycles after 3 accepts -> no rsp pulses afterwards, busy=0, and cordic_* and rsp_* are 0.
REQ-039 Neither valid for 10 cycles -> cordic_* hold their values and no pulses occur.
REQ-040 With CORDIC_ARB_STATS_EN and 70000 req0 accepts -> grant_cnt0=0xFFFF and grant_cnt1=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
// Holds the angle width, the default CORDIC data width, and the
// {valid, tag} entry carried alongside each operation in flight.
package cordic_pkg;

    localparam int ANGLE_W    = 32;
    localparam int SZ_DEFAULT = 16;

    // Requester index: 0 or 1
    typedef logic tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_entry_t;

    // On a tie, the requester that was not granted last wins
    function automatic tag_t tie_winner(input tag_t last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Delay line that carries the {valid, tag} of each accepted operation
// alongside the CORDIC pipeline. It has DEPTH stages and a synchronous
// clear that drops everything in flight.
module cordic_tag_pipe
    import cordic_pkg::*;
#(
    parameter int DEPTH = 17
)
(
    input  logic clk,
    input  logic clear,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag,
    output logic any_valid
);

    tag_entry_t stage_q [DEPTH];
    tag_entry_t stage_d [DEPTH];

    // Each stage takes the value of the stage before it; stage 0 takes the new entry
    always_comb begin
        stage_d[0] = '{valid: in_valid, tag: in_tag};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared together so no stale entry survives a reset
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Report whether any stage holds a live operation
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_tag   = stage_q[DEPTH-1].tag;

endmodule

// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a shared pipelined CORDIC.
// It registers the granted operands into the CORDIC, tracks which
// requester owns each operation in flight, and returns the result
// with a one-cycle response pulse to that requester.
// Optional feature: define CORDIC_ARB_STATS_EN to add the saturating
// 16-bit per-requester grant counters grant_cnt0/grant_cnt1.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int SZ  = SZ_DEFAULT,
    parameter int LAT = 17
)
(
    input  logic               CLK_100MHz,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [ANGLE_W-1:0] req0_angle,
    input  logic [ANGLE_W-1:0] req1_angle,
    input  logic [SZ-1:0]      req0_x,
    input  logic [SZ-1:0]      req0_y,
    input  logic [SZ-1:0]      req1_x,
    input  logic [SZ-1:0]      req1_y,
    output logic [ANGLE_W-1:0] cordic_angle,
    output logic [SZ-1:0]      cordic_xin,
    output logic [SZ-1:0]      cordic_yin,
    input  logic [SZ:0]        cordic_xout,
    input  logic [SZ:0]        cordic_yout,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [SZ:0]        rsp_x,
    output logic [SZ:0]        rsp_y,
    output logic               busy
`ifdef CORDIC_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);

    tag_t               last_grant_q, last_grant_d;
    logic [ANGLE_W-1:0] cordic_angle_q, cordic_angle_d;
    logic [SZ-1:0]      cordic_xin_q, cordic_xin_d;
    logic [SZ-1:0]      cordic_yin_q, cordic_yin_d;
    logic               tail_valid_q, tail_valid_d;
    tag_t               tail_tag_q, tail_tag_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [SZ:0]        rsp_x_q, rsp_x_d;
    logic [SZ:0]        rsp_y_q, rsp_y_d;

    logic accept;
    tag_t grant_idx;
    logic pipe_out_valid;
    logic pipe_out_tag;
    logic pipe_any_valid;

    // Grant: a lone valid wins outright, a tie goes to whoever lost last time
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                if (tie_winner(last_grant_q) == 1'b0) begin
                    req0_ready = 1'b1;
                end else begin
                    req1_ready = 1'b1;
                end
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign accept    = req0_ready | req1_ready;
    assign grant_idx = req1_ready;

    // Load the granted operands into the CORDIC input registers; hold otherwise
    always_comb begin
        last_grant_d   = last_grant_q;
        cordic_angle_d = cordic_angle_q;
        cordic_xin_d   = cordic_xin_q;
        cordic_yin_d   = cordic_yin_q;
        if (accept) begin
            last_grant_d = grant_idx;
            if (grant_idx == 1'b0) begin
                cordic_angle_d = req0_angle;
                cordic_xin_d   = req0_x;
                cordic_yin_d   = req0_y;
            end else begin
                cordic_angle_d = req1_angle;
                cordic_xin_d   = req1_x;
                cordic_yin_d   = req1_y;
            end
        end
    end

    cordic_tag_pipe #(
        .DEPTH (LAT)
    ) u_tag_pipe (
        .clk       (CLK_100MHz),
        .clear     (reset),
        .in_valid  (accept),
        .in_tag    (grant_idx),
        .out_valid (pipe_out_valid),
        .out_tag   (pipe_out_tag),
        .any_valid (pipe_any_valid)
    );

    // The tail stage lines the tag up with the cycle the CORDIC result is
    // present, so the response register captures data and tag together
    always_comb begin
        tail_valid_d = pipe_out_valid;
        tail_tag_d   = pipe_out_tag;
        rsp0_valid_d = tail_valid_q & (tail_tag_q == 1'b0);
        rsp1_valid_d = tail_valid_q & (tail_tag_q == 1'b1);
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        if (tail_valid_q) begin
            rsp_x_d = cordic_xout;
            rsp_y_d = cordic_yout;
        end
    end

    // State registers; reset drops every in-flight operation and favours requester 0
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            cordic_angle_q <= '0;
            cordic_xin_q   <= '0;
            cordic_yin_q   <= '0;
            tail_valid_q   <= 1'b0;
            tail_tag_q     <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp_x_q        <= '0;
            rsp_y_q        <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            cordic_angle_q <= cordic_angle_d;
            cordic_xin_q   <= cordic_xin_d;
            cordic_yin_q   <= cordic_yin_d;
            tail_valid_q   <= tail_valid_d;
            tail_tag_q     <= tail_tag_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp_x_q        <= rsp_x_d;
            rsp_y_q        <= rsp_y_d;
        end
    end

    assign cordic_angle = cordic_angle_q;
    assign cordic_xin   = cordic_xin_q;
    assign cordic_yin   = cordic_yin_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp_x        = rsp_x_q;
    assign rsp_y        = rsp_y_q;
    assign busy         = pipe_any_valid | tail_valid_q | rsp0_valid_q | rsp1_valid_q;

`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    // Count accepts per requester, sticking at all-ones instead of wrapping
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (req0_ready && (grant_cnt0_q != 16'hFFFF)) begin
            grant_cnt0_d = grant_cnt0_q + 16'd1;
        end
        if (req1_ready && (grant_cnt1_q != 16'hFFFF)) begin
            grant_cnt1_d = grant_cnt1_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
